// File: rtl/alu_rf_32.sv
// MIPS datapath core: 32-entry register file feeding a registered ALU whose result is
// written back into the register file two edges after the operands are read.
module alu_rf_32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  write_enabled,
  input  logic [3:0]            control,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cout,
  output logic                  zero,
  output logic                  overflow
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  localparam logic [3:0] OpAnd = 4'h0;
  localparam logic [3:0] OpOr  = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h6;
  localparam logic [3:0] OpSlt = 4'h7;
  localparam logic [3:0] OpNor = 4'hC;

  logic [DATA_WIDTH-1:0] register_file [0:NumRegs-1];

  logic [DATA_WIDTH:0]   sum_add;
  logic [DATA_WIDTH:0]   sum_sub;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  cout_d;
  logic                  overflow_d;

  always_comb begin
    sum_add = {1'b0, out_a} + {1'b0, out_b};
    sum_sub = {1'b0, out_a} + {1'b0, ~out_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    add_ovf = (out_a[DATA_WIDTH-1] == out_b[DATA_WIDTH-1]) &&
              (sum_add[DATA_WIDTH-1] != out_a[DATA_WIDTH-1]);
    sub_ovf = (out_a[DATA_WIDTH-1] != out_b[DATA_WIDTH-1]) &&
              (sum_sub[DATA_WIDTH-1] != out_a[DATA_WIDTH-1]);

    result_d   = '0;
    cout_d     = 1'b0;
    overflow_d = 1'b0;
    case (control)
      OpAnd: result_d = out_a & out_b;
      OpOr:  result_d = out_a | out_b;
      OpAdd: begin
        result_d   = sum_add[DATA_WIDTH-1:0];
        cout_d     = sum_add[DATA_WIDTH];
        overflow_d = add_ovf;
      end
      OpSub: begin
        result_d   = sum_sub[DATA_WIDTH-1:0];
        cout_d     = sum_sub[DATA_WIDTH];
        overflow_d = sub_ovf;
      end
      OpSlt: begin
        // Sign of the true difference: the wrapped sign bit is inverted on overflow
        result_d = {{(DATA_WIDTH-1){1'b0}}, sum_sub[DATA_WIDTH-1] ^ sub_ovf};
        cout_d   = sum_sub[DATA_WIDTH];
      end
      OpNor:   result_d = ~(out_a | out_b);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        register_file[i] <= '0;
      end
      out_a    <= '0;
      out_b    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Reads see the pre-edge contents: no write-to-read bypass
      out_a    <= (rs == '0) ? '0 : register_file[rs];
      out_b    <= (rt == '0) ? '0 : register_file[rt];
      result   <= result_d;
      cout     <= cout_d;
      zero     <= (result_d == '0);
      overflow <= overflow_d;
      if (write_enabled && (rd != '0)) begin
        register_file[rd] <= result;
      end
    end
  end

endmodule

// File: tb/tb_alu_rf_32.sv
// Randomised and directed bench for alu_rf_32 against an instruction-level model of the
// register file (rd = op(rs, rt)).
module tb_alu_rf_32;

  logic        clk;
  logic        reset;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        write_enabled;
  logic [3:0]  control;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        overflow;

  alu_rf_32 dut (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .write_enabled(write_enabled),
    .control      (control),
    .out_a        (out_a),
    .out_b        (out_b),
    .result       (result),
    .cout         (cout),
    .zero         (zero),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fails;
  logic [31:0] m_rf [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction semantics straight from the operation table, in 64-bit arithmetic
  function automatic void alu_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic c, output logic v);
    longint unsigned u;
    longint sa;
    longint sb;
    longint sv;
    longint sr;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'h0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin
        u  = {32'h0, a} + {32'h0, b};
        r  = u[31:0];
        c  = u[32];
        sv = sa + sb;
        sr = $signed(r);
        v  = (sv != sr);
      end
      4'h6: begin
        r  = a - b;
        c  = (a >= b);
        sv = sa - sb;
        sr = $signed(r);
        v  = (sv != sr);
      end
      4'h7: begin
        r = (sa < sb) ? 32'd1 : 32'd0;
        c = (a >= b);
      end
      4'hC: r = ~(a | b);
      default: r = 32'h0;
    endcase
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    dut.register_file[idx] = val;
    m_rf[idx] = val;
  endtask

  // Entered and left at a falling edge; inputs held for read, execute and writeback edges
  task automatic run_op(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s,
                        input logic [4:0] t, input logic we_en);
    logic [31:0] r;
    logic        c;
    logic        v;
    alu_model(op, m_rf[s], m_rf[t], r, c, v);
    rs = s;
    rt = t;
    rd = d;
    control = op;
    write_enabled = 1'b0;
    @(negedge clk);
    check_eq($sformatf("out_a r%0d", s), out_a, m_rf[s]);
    check_eq($sformatf("out_b r%0d", t), out_b, m_rf[t]);
    @(negedge clk);
    write_enabled = we_en;
    @(negedge clk);
    write_enabled = 1'b0;
    if (we_en && d != 5'd0) m_rf[d] = r;
    check_eq($sformatf("result op%0h", op), result, r);
    check_eq($sformatf("cout op%0h", op), {31'h0, cout}, {31'h0, c});
    check_eq($sformatf("zero op%0h", op), {31'h0, zero}, {31'h0, r == 32'h0});
    check_eq($sformatf("ovf op%0h", op), {31'h0, overflow}, {31'h0, v});
    check_eq($sformatf("rf r%0d", d), dut.register_file[d], m_rf[d]);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("%s r%0d", tag, i), dut.register_file[i], m_rf[i]);
    end
  endtask

  logic [3:0] ops [8];
  int         iter;

  initial begin
    n_tests = 0;
    n_fails = 0;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'hF};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    reset = 1'b1;
    rs = 5'd0;
    rt = 5'd0;
    rd = 5'd0;
    write_enabled = 1'b0;
    control = 4'h2;
    #1;
    check_eq("reset out_a", out_a, 32'h0);
    check_eq("reset result", result, 32'h0);
    check_eq("reset flags", {29'h0, cout, zero, overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_all_regs("reset");

    // Add / sub
    preload(2, 32'd16);
    preload(20, 32'd0);
    preload(1, 32'd1);
    run_op(4'h2, 5'd20, 5'd20, 5'd2, 1'b1);
    run_op(4'h2, 5'd21, 5'd20, 5'd2, 1'b1);
    check_eq("add r20", dut.register_file[20], 32'd16);
    check_eq("add r21", dut.register_file[21], 32'd32);
    run_op(4'h6, 5'd22, 5'd20, 5'd1, 1'b1);
    check_eq("sub r22 a", dut.register_file[22], 32'd15);
    check_eq("sub cout a", {31'h0, cout}, 32'd1);
    run_op(4'h6, 5'd22, 5'd22, 5'd1, 1'b1);
    check_eq("sub r22 b", dut.register_file[22], 32'd14);
    check_eq("sub zero b", {31'h0, zero}, 32'd0);

    // Counting loop, bounded in case the exit flag never rises
    preload(3, 32'd4);
    preload(4, 32'd0);
    preload(5, 32'd0);
    iter = 0;
    do begin
      run_op(4'h2, 5'd4, 5'd4, 5'd2, 1'b1);
      run_op(4'h6, 5'd3, 5'd3, 5'd1, 1'b1);
      run_op(4'h7, 5'd5, 5'd3, 5'd1, 1'b1);
      iter++;
    end while (dut.register_file[5] != 32'd1 && iter < 10);
    check_eq("loop iters", iter, 32'd4);
    check_eq("loop r4", dut.register_file[4], 32'd64);
    check_eq("loop r3", dut.register_file[3], 32'd0);
    check_eq("loop r5", dut.register_file[5], 32'd1);

    // Flag corners
    preload(6, 32'h7FFF_FFFF);
    preload(7, 32'hFFFF_FFFF);
    run_op(4'h2, 5'd8, 5'd6, 5'd1, 1'b1);
    check_eq("ovf result", result, 32'h8000_0000);
    check_eq("ovf flag", {31'h0, overflow}, 32'd1);
    run_op(4'h2, 5'd9, 5'd7, 5'd1, 1'b1);
    check_eq("wrap result", result, 32'h0);
    check_eq("wrap cout/zero", {30'h0, cout, zero}, 32'd3);
    run_op(4'h7, 5'd10, 5'd7, 5'd1, 1'b1);
    check_eq("slt -1<1", dut.register_file[10], 32'd1);

    // r0 write and logic ops
    run_op(4'h2, 5'd0, 5'd2, 5'd2, 1'b1);
    check_eq("r0 stays", dut.register_file[0], 32'h0);
    preload(11, 32'h0000_F0F0);
    preload(12, 32'h0000_0FF0);
    run_op(4'h0, 5'd13, 5'd11, 5'd12, 1'b1);
    check_eq("and", dut.register_file[13], 32'h0000_00F0);
    run_op(4'h1, 5'd14, 5'd11, 5'd12, 1'b1);
    check_eq("or", dut.register_file[14], 32'h0000_FFF0);
    run_op(4'hC, 5'd15, 5'd11, 5'd12, 1'b1);
    check_eq("nor", dut.register_file[15], 32'hFFFF_000F);

    // Random instruction stream over a randomly filled file
    for (int i = 1; i < 32; i++) preload(i, $urandom);
    for (int n = 0; n < 60; n++) begin
      run_op(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
    end
    check_all_regs("random");

    // NOOP leaves architectural state unchanged
    run_op(4'h2, 5'd0, 5'd0, 5'd0, 1'b1);
    check_all_regs("noop");

    // Asynchronous reset between edges with live state
    preload(17, 32'hDEAD_BEEF);
    rs = 5'd17;
    rt = 5'd17;
    control = 4'h1;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst out_a", out_a, 32'h0);
    check_eq("midrst out_b", out_b, 32'h0);
    check_eq("midrst result", result, 32'h0);
    check_eq("midrst flags", {29'h0, cout, zero, overflow}, 32'h0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    check_all_regs("midrst");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
